// File: rtl/issue_unit_if.sv
// Decode-to-issue bundle interface.
// Carries the decoded bundle, its operands and the valid/ready handshake
// between the decode stage (master) and the issue unit (slave).
//   dec_valid_in / dec_ready_out : bundle handshake
//   dec_exec_sel_in, dec_uop_in  : execution unit select and uOp
//   dec_pc_sel_in, dec_imm_sel_in: operand mux selects
//   dec_invalid_in               : decode flagged illegal instruction
//   dec_halt_in, dec_halt_count_in: IFU halt request and length
//   dec_opa_in, dec_opb_in, dec_rd_in: operands and destination register
interface issue_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
);
    logic             dec_valid_in;
    logic             dec_ready_out;
    logic [2:0]       dec_exec_sel_in;
    logic [3:0]       dec_uop_in;
    logic             dec_pc_sel_in;
    logic             dec_imm_sel_in;
    logic             dec_invalid_in;
    logic             dec_halt_in;
    logic [3:0]       dec_halt_count_in;
    logic [XLEN-1:0]  dec_opa_in;
    logic [XLEN-1:0]  dec_opb_in;
    logic [RADDR-1:0] dec_rd_in;

    modport master (
        output dec_valid_in, dec_exec_sel_in, dec_uop_in, dec_pc_sel_in,
               dec_imm_sel_in, dec_invalid_in, dec_halt_in, dec_halt_count_in,
               dec_opa_in, dec_opb_in, dec_rd_in,
        input  dec_ready_out
    );

    modport slave (
        input  dec_valid_in, dec_exec_sel_in, dec_uop_in, dec_pc_sel_in,
               dec_imm_sel_in, dec_invalid_in, dec_halt_in, dec_halt_count_in,
               dec_opa_in, dec_opb_in, dec_rd_in,
        output dec_ready_out
    );
endinterface

// File: rtl/issue_unit.sv
// Issue unit: one-entry issue register between decode and the execution units.
// Accepts a decoded bundle over the decode interface, holds it, and dispatches
// it to INT, BRU, LSU or VEC over a per-unit valid/ready handshake. Illegal
// bundles are dropped with a one-cycle exception pulse. Also owns the IFU halt
// countdown requested by decode.
//   clock_in, reset_in (sync, active low)
//   dec            : decode bundle interface (slave side)
//   *_valid_out    : per-unit dispatch valid; *_ready_in : per-unit ready
//   iss_*_out      : registered payload of the held bundle
//   ifu_halt_out   : fetch stall; exc_illegal_out : illegal-instruction pulse
module issue_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic             clock_in,
    input  logic             reset_in,
    issue_unit_if.slave      dec,
    output logic             int_valid_out,
    output logic             bru_valid_out,
    output logic             lsu_valid_out,
    output logic             vec_valid_out,
    input  logic             int_ready_in,
    input  logic             bru_ready_in,
    input  logic             lsu_ready_in,
    input  logic             vec_ready_in,
    output logic [3:0]       iss_uop_out,
    output logic [XLEN-1:0]  iss_opa_out,
    output logic [XLEN-1:0]  iss_opb_out,
    output logic [RADDR-1:0] iss_rd_out,
    output logic [1:0]       iss_flags_out,
    output logic             ifu_halt_out,
    output logic             exc_illegal_out
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t     state_q, state_d;
    logic [3:0] unit_q;      // one-hot {vec, lsu, bru, int} of the held entry
    logic [3:0] unit_dec;    // one-hot decode of the incoming select
    logic [3:0] halt_cnt_q, halt_cnt_d;
    logic       legal;
    logic       fire;
    logic       ready;
    logic       accept;
    logic       load;

    always_comb begin
        unit_dec = '0;
        case (dec.dec_exec_sel_in)
            3'b001:  unit_dec = 4'b0001;
            3'b011:  unit_dec = 4'b0010;
            3'b010:  unit_dec = 4'b0100;
            3'b100:  unit_dec = 4'b1000;
            default: unit_dec = '0;
        endcase
    end

    assign legal  = ~dec.dec_invalid_in & (unit_dec != '0);
    // Only the ready of the unit the held entry targets matters.
    assign fire   = (state_q == FULL) &
                    (|(unit_q & {vec_ready_in, lsu_ready_in, bru_ready_in, int_ready_in}));
    assign ready  = (halt_cnt_q == '0) & ((state_q == EMPTY) | fire);
    assign accept = dec.dec_valid_in & ready;
    assign load   = accept & legal;

    assign dec.dec_ready_out = ready;

    always_ff @(posedge clock_in) begin
        if (!reset_in) state_q <= EMPTY;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL: begin
                if (load)      state_d = FULL;
                else if (fire) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        {vec_valid_out, lsu_valid_out, bru_valid_out, int_valid_out} =
            (state_q == FULL) ? unit_q : 4'b0000;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            unit_q        <= '0;
            iss_uop_out   <= '0;
            iss_opa_out   <= '0;
            iss_opb_out   <= '0;
            iss_rd_out    <= '0;
            iss_flags_out <= '0;
        end else if (load) begin
            unit_q        <= unit_dec;
            iss_uop_out   <= dec.dec_uop_in;
            iss_opa_out   <= dec.dec_opa_in;
            iss_opb_out   <= dec.dec_opb_in;
            iss_rd_out    <= dec.dec_rd_in;
            iss_flags_out <= {dec.dec_pc_sel_in, dec.dec_imm_sel_in};
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) exc_illegal_out <= 1'b0;
        else           exc_illegal_out <= accept & ~legal;
    end

    // A zero halt length still stalls for one cycle. Accept is only possible
    // with the counter at zero, so load and decrement never collide.
    always_comb begin
        halt_cnt_d = halt_cnt_q;
        if (accept && dec.dec_halt_in)
            halt_cnt_d = (dec.dec_halt_count_in == '0) ? 4'd1 : dec.dec_halt_count_in;
        else if (halt_cnt_q != '0)
            halt_cnt_d = halt_cnt_q - 4'd1;
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            halt_cnt_q   <= '0;
            ifu_halt_out <= 1'b0;
        end else begin
            halt_cnt_q   <= halt_cnt_d;
            ifu_halt_out <= (halt_cnt_d != '0);
        end
    end

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit: directed scenarios plus a randomized run
// checked against a transaction-level model with an in-order dispatch queue.
module tb_issue_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    issue_unit_if #(.XLEN(32), .RADDR(5)) dif();

    logic        int_v, bru_v, lsu_v, vec_v;
    logic        int_r, bru_r, lsu_r, vec_r;
    logic [3:0]  iss_uop;
    logic [31:0] iss_opa, iss_opb;
    logic [4:0]  iss_rd;
    logic [1:0]  iss_flags;
    logic        ifu_halt, exc_ill;
    logic [3:0]  valids;

    assign valids = {vec_v, lsu_v, bru_v, int_v};

    issue_unit #(.XLEN(32), .RADDR(5)) dut (
        .clock_in        (clk),
        .reset_in        (rst_n),
        .dec             (dif.slave),
        .int_valid_out   (int_v),
        .bru_valid_out   (bru_v),
        .lsu_valid_out   (lsu_v),
        .vec_valid_out   (vec_v),
        .int_ready_in    (int_r),
        .bru_ready_in    (bru_r),
        .lsu_ready_in    (lsu_r),
        .vec_ready_in    (vec_r),
        .iss_uop_out     (iss_uop),
        .iss_opa_out     (iss_opa),
        .iss_opb_out     (iss_opb),
        .iss_rd_out      (iss_rd),
        .iss_flags_out   (iss_flags),
        .ifu_halt_out    (ifu_halt),
        .exc_illegal_out (exc_ill)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  uop;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [4:0]  rd;
        logic [1:0]  flags;
        int          unit;   // 0 INT, 1 BRU, 2 LSU, 3 VEC
    } ent_t;

    function automatic int sel_to_unit(input logic [2:0] s);
        case (s)
            3'b001:  return 0;
            3'b011:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return -1;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [2:0] sel, input logic [3:0] uop,
                         input logic inv, input logic h, input logic [3:0] hc,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        dif.dec_valid_in      = v;
        dif.dec_exec_sel_in   = sel;
        dif.dec_uop_in        = uop;
        dif.dec_pc_sel_in     = 1'b0;
        dif.dec_imm_sel_in    = 1'b1;
        dif.dec_invalid_in    = inv;
        dif.dec_halt_in       = h;
        dif.dec_halt_count_in = hc;
        dif.dec_opa_in        = a;
        dif.dec_opb_in        = b;
        dif.dec_rd_in         = rd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'h0);
        {int_r, bru_r, lsu_r, vec_r} = 4'b1111;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (valids !== 4'b0000) begin failures++; $display("FAIL reset_valids got=%b exp=0000", valids); end
        checks++; if (dif.dec_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", dif.dec_ready_out); end
        checks++; if (ifu_halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", ifu_halt); end
        checks++; if (exc_ill !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", exc_ill); end
        checks++; if ({iss_uop, iss_opa, iss_opb, iss_rd, iss_flags} !== '0) begin
            failures++; $display("FAIL reset_payload got uop=%h opa=%h opb=%h rd=%h exp=0", iss_uop, iss_opa, iss_opb, iss_rd); end
    endtask

    task automatic test_add();
        do_reset();
        drive(1'b1, 3'b001, 4'h0, 1'b0, 1'b0, 4'h0, 32'd5, 32'd7, 5'd3);
        cyc();
        dif.dec_valid_in = 1'b0;
        @(negedge clk);
        checks++; if (valids !== 4'b0001) begin failures++; $display("FAIL add_valid got=%b exp=0001", valids); end
        checks++; if ({iss_uop, iss_opa, iss_opb, iss_rd} !== {4'h0, 32'd5, 32'd7, 5'd3}) begin
            failures++; $display("FAIL add_payload got uop=%h opa=%0d opb=%0d rd=%0d exp 0/5/7/3", iss_uop, iss_opa, iss_opb, iss_rd); end
        checks++; if (iss_flags !== 2'b01) begin failures++; $display("FAIL add_flags got=%b exp=01", iss_flags); end
        cyc();
        @(negedge clk);
        checks++; if (valids !== 4'b0000) begin failures++; $display("FAIL add_one_cycle got=%b exp=0000", valids); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 3'b010, 4'h3, 1'b0, 1'b0, 4'h0, 32'h11, 32'h12, 5'd1);
        cyc();
        drive(1'b1, 3'b010, 4'h9, 1'b0, 1'b0, 4'h0, 32'h21, 32'h22, 5'd2);
        @(negedge clk);
        checks++; if (valids !== 4'b0100 || iss_uop !== 4'h3 || dif.dec_ready_out !== 1'b1) begin
            failures++; $display("FAIL b2b_first got valids=%b uop=%h rdy=%b exp 0100/3/1", valids, iss_uop, dif.dec_ready_out); end
        cyc();
        lsu_r = 1'b0;
        drive(1'b1, 3'b010, 4'hC, 1'b0, 1'b0, 4'h0, 32'h31, 32'h32, 5'd3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (valids !== 4'b0100 || iss_uop !== 4'h9 || iss_opa !== 32'h21 || dif.dec_ready_out !== 1'b0) begin
                failures++; $display("FAIL b2b_stall%0d got valids=%b uop=%h opa=%h rdy=%b exp 0100/9/21/0", i, valids, iss_uop, iss_opa, dif.dec_ready_out); end
            cyc();
        end
        lsu_r = 1'b1;
        @(negedge clk);
        checks++; if (valids !== 4'b0100 || iss_uop !== 4'h9 || dif.dec_ready_out !== 1'b1) begin
            failures++; $display("FAIL b2b_release got valids=%b uop=%h rdy=%b exp 0100/9/1", valids, iss_uop, dif.dec_ready_out); end
        cyc();
        dif.dec_valid_in = 1'b0;
        @(negedge clk);
        checks++; if (valids !== 4'b0100 || iss_uop !== 4'hC) begin
            failures++; $display("FAIL b2b_third got valids=%b uop=%h exp 0100/c", valids, iss_uop); end
        cyc();
        @(negedge clk);
        checks++; if (valids !== 4'b0000) begin failures++; $display("FAIL b2b_drained got=%b exp=0000", valids); end
    endtask

    task automatic test_halt();
        do_reset();
        drive(1'b1, 3'b011, 4'h1, 1'b0, 1'b1, 4'd2, 32'h100, 32'h8, 5'd0);
        cyc();
        dif.dec_valid_in = 1'b0;
        dif.dec_halt_in  = 1'b0;
        @(negedge clk);
        checks++; if (valids !== 4'b0010 || ifu_halt !== 1'b1 || dif.dec_ready_out !== 1'b0) begin
            failures++; $display("FAIL halt2_c1 got valids=%b halt=%b rdy=%b exp 0010/1/0", valids, ifu_halt, dif.dec_ready_out); end
        cyc();
        @(negedge clk);
        checks++; if (valids !== 4'b0000 || ifu_halt !== 1'b1 || dif.dec_ready_out !== 1'b0) begin
            failures++; $display("FAIL halt2_c2 got valids=%b halt=%b rdy=%b exp 0000/1/0", valids, ifu_halt, dif.dec_ready_out); end
        cyc();
        @(negedge clk);
        checks++; if (ifu_halt !== 1'b0 || dif.dec_ready_out !== 1'b1) begin
            failures++; $display("FAIL halt2_end got halt=%b rdy=%b exp 0/1", ifu_halt, dif.dec_ready_out); end
        drive(1'b1, 3'b011, 4'h1, 1'b0, 1'b1, 4'd0, 32'h200, 32'h8, 5'd0);
        cyc();
        dif.dec_valid_in = 1'b0;
        dif.dec_halt_in  = 1'b0;
        @(negedge clk);
        checks++; if (ifu_halt !== 1'b1 || dif.dec_ready_out !== 1'b0) begin
            failures++; $display("FAIL halt0_c1 got halt=%b rdy=%b exp 1/0", ifu_halt, dif.dec_ready_out); end
        cyc();
        @(negedge clk);
        checks++; if (ifu_halt !== 1'b0 || dif.dec_ready_out !== 1'b1) begin
            failures++; $display("FAIL halt0_end got halt=%b rdy=%b exp 0/1", ifu_halt, dif.dec_ready_out); end
    endtask

    task automatic test_illegal();
        do_reset();
        vec_r = 1'b0;
        drive(1'b1, 3'b100, 4'h5, 1'b0, 1'b0, 4'h0, 32'hA5A5, 32'h5A5A, 5'd7);
        cyc();
        drive(1'b1, 3'b000, 4'hF, 1'b0, 1'b0, 4'h0, 32'hDEAD, 32'hBEEF, 5'd9);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (valids !== 4'b1000 || iss_uop !== 4'h5 || iss_opa !== 32'hA5A5 || iss_rd !== 5'd7 || exc_ill !== 1'b0) begin
                failures++; $display("FAIL ill_wait%0d got valids=%b uop=%h opa=%h rd=%0d exc=%b exp 1000/5/a5a5/7/0", i, valids, iss_uop, iss_opa, iss_rd, exc_ill); end
            cyc();
        end
        vec_r = 1'b1;
        cyc();
        dif.dec_valid_in = 1'b0;
        @(negedge clk);
        checks++; if (exc_ill !== 1'b1 || valids !== 4'b0000 || iss_uop !== 4'h5) begin
            failures++; $display("FAIL ill_pulse got exc=%b valids=%b uop=%h exp 1/0000/5", exc_ill, valids, iss_uop); end
        cyc();
        @(negedge clk);
        checks++; if (exc_ill !== 1'b0) begin failures++; $display("FAIL ill_single got exc=%b exp=0", exc_ill); end
        drive(1'b1, 3'b001, 4'h2, 1'b1, 1'b0, 4'h0, 32'h1, 32'h2, 5'd4);
        cyc();
        dif.dec_valid_in = 1'b0;
        @(negedge clk);
        checks++; if (exc_ill !== 1'b1 || valids !== 4'b0000) begin
            failures++; $display("FAIL ill_flag got exc=%b valids=%b exp 1/0000", exc_ill, valids); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bru_r = 1'b0;
        drive(1'b1, 3'b011, 4'h2, 1'b0, 1'b1, 4'd3, 32'h40, 32'h4, 5'd1);
        cyc();
        dif.dec_valid_in = 1'b0;
        dif.dec_halt_in  = 1'b0;
        cyc();
        @(negedge clk);
        checks++; if (valids !== 4'b0010 || ifu_halt !== 1'b1) begin
            failures++; $display("FAIL rmid_pre got valids=%b halt=%b exp 0010/1", valids, ifu_halt); end
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (valids !== 4'b0000 || ifu_halt !== 1'b0 || dif.dec_ready_out !== 1'b1 || iss_uop !== 4'h0) begin
            failures++; $display("FAIL rmid_post got valids=%b halt=%b rdy=%b uop=%h exp 0000/0/1/0", valids, ifu_halt, dif.dec_ready_out, iss_uop); end
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        m_pay;
        ent_t        got;
        bit          m_occ;
        int          m_halt;
        bit          m_exc;
        bit          m_fire, exp_rdy, acc;
        int          u;
        logic [3:0]  rdy_vec, exp_val;
        logic [2:0]  legal_sel[4];
        legal_sel[0] = 3'b001; legal_sel[1] = 3'b011; legal_sel[2] = 3'b010; legal_sel[3] = 3'b100;
        do_reset();
        m_pay = '{uop: 4'h0, opa: 32'h0, opb: 32'h0, rd: 5'h0, flags: 2'b00, unit: 0};
        m_occ = 0; m_halt = 0; m_exc = 0;
        for (int c = 0; c < 1500; c++) begin
            dif.dec_valid_in      = ($urandom_range(0, 9) < 7);
            dif.dec_exec_sel_in   = ($urandom_range(0, 9) < 8) ? legal_sel[$urandom_range(0, 3)]
                                                                : 3'($urandom_range(0, 7));
            dif.dec_uop_in        = 4'($urandom);
            dif.dec_pc_sel_in     = 1'($urandom);
            dif.dec_imm_sel_in    = 1'($urandom);
            dif.dec_invalid_in    = ($urandom_range(0, 19) == 0);
            dif.dec_halt_in       = ($urandom_range(0, 11) == 0);
            dif.dec_halt_count_in = 4'($urandom_range(0, 5));
            dif.dec_opa_in        = $urandom;
            dif.dec_opb_in        = $urandom;
            dif.dec_rd_in         = 5'($urandom);
            int_r = ($urandom_range(0, 9) < 6);
            bru_r = ($urandom_range(0, 9) < 6);
            lsu_r = ($urandom_range(0, 9) < 6);
            vec_r = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            rdy_vec = {vec_r, lsu_r, bru_r, int_r};
            exp_val = m_occ ? (4'b0001 << m_pay.unit) : 4'b0000;
            m_fire  = m_occ && rdy_vec[m_pay.unit];
            exp_rdy = (m_halt == 0) && (!m_occ || m_fire);
            checks++; if (valids !== exp_val) begin failures++; $display("FAIL rnd_valids c=%0d got=%b exp=%b", c, valids, exp_val); end
            checks++; if (dif.dec_ready_out !== exp_rdy) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, dif.dec_ready_out, exp_rdy); end
            checks++; if (ifu_halt !== (m_halt != 0)) begin failures++; $display("FAIL rnd_halt c=%0d got=%b exp=%0d", c, ifu_halt, m_halt != 0); end
            checks++; if (exc_ill !== m_exc) begin failures++; $display("FAIL rnd_exc c=%0d got=%b exp=%b", c, exc_ill, m_exc); end
            checks++; if ({iss_uop, iss_opa, iss_opb, iss_rd, iss_flags} !== {m_pay.uop, m_pay.opa, m_pay.opb, m_pay.rd, m_pay.flags}) begin
                failures++; $display("FAIL rnd_payload c=%0d got uop=%h opa=%h rd=%0d exp uop=%h opa=%h rd=%0d", c, iss_uop, iss_opa, iss_rd, m_pay.uop, m_pay.opa, m_pay.rd); end
            if ((valids & rdy_vec) != 4'b0000) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rnd_dispatch c=%0d got unexpected fire valids=%b exp none", c, valids);
                end else begin
                    got = q.pop_front();
                    if (valids !== (4'b0001 << got.unit) || iss_uop !== got.uop || iss_opa !== got.opa || iss_opb !== got.opb || iss_rd !== got.rd) begin
                        failures++; $display("FAIL rnd_dispatch c=%0d got valids=%b uop=%h opa=%h exp unit=%0d uop=%h opa=%h", c, valids, iss_uop, iss_opa, got.unit, got.uop, got.opa);
                    end
                end
            end
            acc = dif.dec_valid_in && exp_rdy;
            u   = dif.dec_invalid_in ? -1 : sel_to_unit(dif.dec_exec_sel_in);
            if (acc && u >= 0) begin
                m_pay = '{uop: dif.dec_uop_in, opa: dif.dec_opa_in, opb: dif.dec_opb_in, rd: dif.dec_rd_in,
                          flags: {dif.dec_pc_sel_in, dif.dec_imm_sel_in}, unit: u};
                q.push_back(m_pay);
                m_occ = 1;
            end else if (m_fire) begin
                m_occ = 0;
            end
            m_exc = acc && (u < 0);
            if (acc && dif.dec_halt_in) m_halt = (dif.dec_halt_count_in == 0) ? 1 : int'(dif.dec_halt_count_in);
            else if (m_halt > 0)        m_halt = m_halt - 1;
            cyc();
        end
        checks++; if (q.size() > 1) begin failures++; $display("FAIL rnd_leftover got=%0d exp<=1", q.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_halt();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
